// File: rtl/assoc_data_cache_pkg.sv
// Shared definitions for the set-associative data cache: RV32 load/store size
// encodings, refill state machine states and the alignment rule.
package assoc_data_cache_pkg;

    typedef enum logic [2:0] {
        F3_BYTE   = 3'b000,
        F3_HALF   = 3'b001,
        F3_WORD   = 3'b010,
        F3_BYTE_U = 3'b100,
        F3_HALF_U = 3'b101
    } funct3_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_FETCH,
        ST_FILL
    } cache_state_t;

    // Halfwords need an even byte offset, words (and reserved sizes) a zero one.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] byte_off);
        case (funct3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return byte_off[0];
            default: return |byte_off;
        endcase
    endfunction

endpackage

// File: rtl/cache_word_align.sv
// Load-side byte/halfword extraction with sign/zero extension, and store-side
// byte merge of new data into the existing 32-bit word.
module cache_word_align
    import assoc_data_cache_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_in[{byte_off, 3'b000} +: 8];
        half_sel = word_in[{byte_off[1], 4'b0000} +: 16];
        case (funct3)
            F3_BYTE:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BYTE_U: load_data = {24'h000000, byte_sel};
            F3_HALF:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_HALF_U: load_data = {16'h0000, half_sel};
            default:   load_data = word_in;
        endcase
    end

    always_comb begin
        store_word = word_in;
        case (funct3[1:0])
            2'b00:   store_word[{byte_off, 3'b000} +: 8]     = store_data[7:0];
            2'b01:   store_word[{byte_off[1], 4'b0000} +: 16] = store_data[15:0];
            default: store_word = store_data;
        endcase
    end

endmodule

// File: rtl/assoc_data_cache.sv
// Write-back, write-allocate set-associative data cache with combinational hit
// path, age-counter LRU replacement and a single-line refill state machine.
module assoc_data_cache
    import assoc_data_cache_pkg::*;
#(
    parameter  int WAYS       = 2,
    parameter  int SETS       = 8,
    parameter  int LINE_WORDS = 4,
    localparam int LINE_W     = 32 * LINE_WORDS,
    localparam int OFF_W      = $clog2(LINE_W / 8),
    localparam int MA_W       = 32 - OFF_W
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              busywait,
    output logic              misaligned,
    output logic              mem_read,
    output logic              mem_write,
    output logic [MA_W-1:0]   mem_address,
    output logic [LINE_W-1:0] mem_write_data,
    input  logic [LINE_W-1:0] mem_read_data,
    input  logic              mem_busywait
);

    localparam int WOFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int AGE_W  = WAY_W;

    logic [LINE_W-1:0] data_mem [WAYS][SETS];
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [SETS-1:0]   valid_reg [WAYS];
    logic [SETS-1:0]   dirty_reg [WAYS];
    logic [AGE_W-1:0]  age_reg  [WAYS][SETS];

    cache_state_t      state_reg, state_next;
    logic [WAY_W-1:0]  victim_reg;
    logic [MA_W-1:0]   req_line_reg;
    logic [LINE_W-1:0] fill_reg;

    logic [1:0]        byte_off;
    logic [WOFF_W-1:0] word_off;
    logic [IDX_W-1:0]  index;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  req_index;
    logic [TAG_W-1:0]  req_tag;

    assign byte_off  = address[1:0];
    assign word_off  = address[OFF_W-1:2];
    assign index     = address[OFF_W+IDX_W-1:OFF_W];
    assign tag       = address[31:OFF_W+IDX_W];
    assign req_index = req_line_reg[IDX_W-1:0];
    assign req_tag   = req_line_reg[MA_W-1:IDX_W];

    // Tag compare per way; at most one way can match a valid tag.
    logic [WAYS-1:0] way_hit;
    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            assign way_hit[gi] = valid_reg[gi][index] && (tag_mem[gi][index] == tag);
        end
    endgenerate

    logic [WAY_W-1:0] hit_way;
    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) hit_way = WAY_W'(w);
        end
    end

    logic request, access, hit_access, miss;
    assign request    = read || write;
    assign misaligned = request && is_misaligned(funct3, byte_off);
    assign access     = request && !misaligned && (state_reg == ST_IDLE);
    assign hit_access = access && (|way_hit);
    assign miss       = access && !(|way_hit);

    logic [LINE_W-1:0] hit_line;
    logic [31:0]       hit_word, load_word, store_word;
    assign hit_line = data_mem[hit_way][index];
    assign hit_word = hit_line[{word_off, 5'b00000} +: 32];

    cache_word_align u_align (
        .word_in    (hit_word),
        .byte_off   (byte_off),
        .funct3     (funct3),
        .store_data (write_data),
        .load_data  (load_word),
        .store_word (store_word)
    );

    assign read_data = (hit_access && !write) ? load_word : 32'h0;

    // Victim: first invalid way, otherwise the oldest (lowest index on ties).
    logic [WAY_W-1:0] victim_way, lru_way;
    logic [AGE_W-1:0] best_age;
    logic             free_found;
    always_comb begin
        best_age   = age_reg[0][index];
        lru_way    = '0;
        victim_way = '0;
        free_found = 1'b0;
        for (int w = 1; w < WAYS; w++) begin
            if (age_reg[w][index] > best_age) begin
                best_age = age_reg[w][index];
                lru_way  = WAY_W'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!valid_reg[w][index] && !free_found) begin
                victim_way = WAY_W'(w);
                free_found = 1'b1;
            end
        end
        if (!free_found) victim_way = lru_way;
    end

    logic victim_dirty;
    assign victim_dirty = valid_reg[victim_way][index] && dirty_reg[victim_way][index];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (miss) state_next = victim_dirty ? ST_WRITEBACK : ST_FETCH;
            ST_WRITEBACK: if (!mem_busywait) state_next = ST_FETCH;
            ST_FETCH:     if (!mem_busywait) state_next = ST_FILL;
            ST_FILL:      state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        busywait       = (state_reg != ST_IDLE) || miss;
        case (state_reg)
            ST_WRITEBACK: begin
                mem_write      = 1'b1;
                mem_address    = {tag_mem[victim_reg][req_index], req_index};
                mem_write_data = data_mem[victim_reg][req_index];
            end
            ST_FETCH: begin
                mem_read    = 1'b1;
                mem_address = req_line_reg;
            end
            default: ;
        endcase
    end

    // A fill counts as the oldest way being used, so every other way ages.
    logic             touch_en;
    logic [WAY_W-1:0] touch_way;
    logic [IDX_W-1:0] touch_set;
    logic [AGE_W-1:0] touch_limit;
    always_comb begin
        touch_en    = hit_access || (state_reg == ST_FILL);
        touch_way   = hit_way;
        touch_set   = index;
        touch_limit = age_reg[hit_way][index];
        if (state_reg == ST_FILL) begin
            touch_way   = victim_reg;
            touch_set   = req_index;
            touch_limit = AGE_W'(WAYS - 1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_reg[w] <= '0;
                dirty_reg[w] <= '0;
                for (int s = 0; s < SETS; s++) age_reg[w][s] <= '0;
            end
        end else begin
            if (hit_access && write) dirty_reg[hit_way][index] <= 1'b1;
            if (state_reg == ST_FILL) begin
                valid_reg[victim_reg][req_index] <= 1'b1;
                dirty_reg[victim_reg][req_index] <= 1'b0;
            end
            if (touch_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == touch_way)
                        age_reg[w][touch_set] <= '0;
                    else if (age_reg[w][touch_set] < touch_limit)
                        age_reg[w][touch_set] <= age_reg[w][touch_set] + AGE_W'(1);
                end
            end
        end
    end

    // Payload storage: never reset, only qualified by the valid bits above.
    always_ff @(posedge clock) begin
        if (miss) begin
            victim_reg   <= victim_way;
            req_line_reg <= {tag, index};
        end
        if (state_reg == ST_FETCH && !mem_busywait) fill_reg <= mem_read_data;
        if (state_reg == ST_FILL) begin
            data_mem[victim_reg][req_index] <= fill_reg;
            tag_mem[victim_reg][req_index]  <= req_tag;
        end
        if (hit_access && write)
            data_mem[hit_way][index][{word_off, 5'b00000} +: 32] <= store_word;
    end

endmodule
